// File: rtl/wptr_full_ctrl.sv
// Write-domain pointer/status controller for the async FIFO: binary/Gray write pointer,
// read-pointer synchroniser, full / almost_full / fill count and sticky overflow.
module wptr_full_ctrl #(
   parameter int unsigned PTR_WIDTH    = 4,
   parameter int unsigned SYNC_STAGES  = 2,
   parameter int unsigned AFULL_THRESH = 12
) (
   input  logic                 wclk,
   input  logic                 wrst,
   input  logic                 w_en,
   input  logic [PTR_WIDTH:0]   g_rptr_async,
   input  logic                 ovf_clr,
   output logic [PTR_WIDTH:0]   b_wptr,
   output logic [PTR_WIDTH:0]   g_wptr,
   output logic                 full,
   output logic                 almost_full,
   output logic [PTR_WIDTH:0]   wr_count,
   output logic                 overflow
);

   localparam int unsigned PW = PTR_WIDTH + 1;

   logic [PW-1:0] sync_q [SYNC_STAGES];
   logic [PW-1:0] rq;
   logic [PW-1:0] rq_bin;
   logic [PW-1:0] b_wptr_nx;
   logic [PW-1:0] g_wptr_nx;
   logic [PW-1:0] cnt_nx;
   logic          wr_acc;
   logic          full_nx;
   logic          afull_nx;

   assign rq = sync_q[SYNC_STAGES-1];

   // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
   always_comb begin
      rq_bin = '0;
      for (int i = 0; i < int'(PW); i++) begin
         rq_bin[i] = ^(rq >> i);
      end
   end

   assign wr_acc    = w_en & ~full;
   assign b_wptr_nx = wr_acc ? b_wptr + PW'(1) : b_wptr;
   assign g_wptr_nx = b_wptr_nx ^ (b_wptr_nx >> 1);

   // Flags come from next-state pointers so they line up with the pointer move.
   assign full_nx  = (g_wptr_nx == {~rq[PW-1:PW-2], rq[PW-3:0]});
   assign cnt_nx   = b_wptr_nx - rq_bin;
   assign afull_nx = (cnt_nx >= PW'(AFULL_THRESH));

   always_ff @(posedge wclk) begin
      if (wrst) begin
         for (int i = 0; i < int'(SYNC_STAGES); i++) begin
            sync_q[i] <= '0;
         end
      end else begin
         sync_q[0] <= g_rptr_async;
         for (int i = 1; i < int'(SYNC_STAGES); i++) begin
            sync_q[i] <= sync_q[i-1];
         end
      end
   end

   always_ff @(posedge wclk) begin
      if (wrst) begin
         b_wptr      <= '0;
         g_wptr      <= '0;
         full        <= 1'b0;
         almost_full <= 1'b0;
         wr_count    <= '0;
         overflow    <= 1'b0;
      end else begin
         b_wptr      <= b_wptr_nx;
         g_wptr      <= g_wptr_nx;
         full        <= full_nx;
         almost_full <= afull_nx;
         wr_count    <= cnt_nx;
         // A rejected write sets the flag even when a clear arrives on the same edge.
         if (w_en && full) begin
            overflow <= 1'b1;
         end else if (ovf_clr) begin
            overflow <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_wptr_full_ctrl.sv
// Directed bench for wptr_full_ctrl: vector table for reset/fill/overflow/drain,
// hand-written sequences for pointer wrap, same-edge read+write and mid-fill reset.
module tb_wptr_full_ctrl;

   logic       wclk = 1'b0;
   logic       wrst;
   logic       w_en;
   logic [4:0] g_rptr_async;
   logic       ovf_clr;
   logic [4:0] b_wptr;
   logic [4:0] g_wptr;
   logic       full;
   logic       almost_full;
   logic [4:0] wr_count;
   logic       overflow;

   int passed = 0;
   int total  = 0;

   typedef struct {
      logic       rst;
      logic       w;
      logic       clr;
      logic [4:0] g;
      logic [4:0] b;
      logic       f;
      logic       af;
      logic [4:0] c;
      logic       o;
   } vec_t;

   vec_t vq[$];

   wptr_full_ctrl #(.PTR_WIDTH(4), .SYNC_STAGES(2), .AFULL_THRESH(12)) dut (
      .wclk(wclk), .wrst(wrst), .w_en(w_en), .g_rptr_async(g_rptr_async),
      .ovf_clr(ovf_clr), .b_wptr(b_wptr), .g_wptr(g_wptr), .full(full),
      .almost_full(almost_full), .wr_count(wr_count), .overflow(overflow)
   );

   always #5 wclk = ~wclk;

   function automatic logic [4:0] gray(input logic [4:0] b);
      return b ^ (b >> 1);
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   task automatic add(input logic rst, input logic w, input logic clr, input logic [4:0] g,
                      input logic [4:0] b, input logic f, input logic af,
                      input logic [4:0] c, input logic o);
      vec_t v;
      v.rst = rst; v.w = w; v.clr = clr; v.g = g;
      v.b = b; v.f = f; v.af = af; v.c = c; v.o = o;
      vq.push_back(v);
   endtask

   task automatic step(input logic rst, input logic w, input logic clr, input logic [4:0] g);
      wrst = rst; w_en = w; ovf_clr = clr; g_rptr_async = g;
      @(posedge wclk);
      #1;
   endtask

   initial begin
      wrst = 1'b1; w_en = 1'b0; ovf_clr = 1'b0; g_rptr_async = '0;

      // reset held two cycles with a write request pending
      add(1, 1, 0, 5'b00000, 0, 0, 0, 0, 0);
      add(1, 1, 0, 5'b00000, 0, 0, 0, 0, 0);
      // fill 16 slots; almost_full from the 12th write, full on the 16th
      for (int i = 1; i <= 16; i++)
         add(0, 1, 0, 5'b00000, 5'(i), (i == 16), (i >= 12), 5'(i), 0);
      // write while full, clear, then set-beats-clear
      add(0, 1, 0, 5'b00000, 16, 1, 1, 16, 1);
      add(0, 0, 1, 5'b00000, 16, 1, 1, 16, 0);
      add(0, 1, 0, 5'b00000, 16, 1, 1, 16, 1);
      add(0, 1, 1, 5'b00000, 16, 1, 1, 16, 1);
      add(0, 0, 1, 5'b00000, 16, 1, 1, 16, 0);
      // read pointer to 4: visible exactly on the third edge
      add(0, 0, 0, 5'b00110, 16, 1, 1, 16, 0);
      add(0, 0, 0, 5'b00110, 16, 1, 1, 16, 0);
      add(0, 0, 0, 5'b00110, 16, 0, 1, 12, 0);
      // read pointer to 5: drops below the almost-full threshold
      add(0, 0, 0, 5'b00111, 16, 0, 1, 12, 0);
      add(0, 0, 0, 5'b00111, 16, 0, 1, 12, 0);
      add(0, 0, 0, 5'b00111, 16, 0, 0, 11, 0);

      foreach (vq[i]) begin
         step(vq[i].rst, vq[i].w, vq[i].clr, vq[i].g);
         chk($sformatf("v%0d.b_wptr", i), int'(b_wptr), int'(vq[i].b));
         chk($sformatf("v%0d.g_wptr", i), int'(g_wptr), int'(gray(vq[i].b)));
         chk($sformatf("v%0d.full", i), int'(full), int'(vq[i].f));
         chk($sformatf("v%0d.almost_full", i), int'(almost_full), int'(vq[i].af));
         chk($sformatf("v%0d.wr_count", i), int'(wr_count), int'(vq[i].c));
         chk($sformatf("v%0d.overflow", i), int'(overflow), int'(vq[i].o));
      end
      chk("fill.g_wptr_16", int'(g_wptr), 24);

      // wrap: 40 writes with the read pointer trailing four behind
      step(1, 0, 0, 5'b00000);
      for (int j = 1; j <= 40; j++) begin
         step(0, 1, 0, (j > 4) ? gray(5'(j - 4)) : 5'b00000);
         chk($sformatf("wrap%0d.b_wptr", j), int'(b_wptr), j % 32);
         chk($sformatf("wrap%0d.g_wptr", j), int'(g_wptr), int'(gray(5'(j))));
         chk($sformatf("wrap%0d.full", j), int'(full), 0);
         chk($sformatf("wrap%0d.count_le8", j), int'(wr_count <= 5'd8), 1);
      end

      // same-edge write and read-pointer arrival at count 15
      step(1, 0, 0, 5'b00000);
      for (int j = 1; j <= 15; j++) step(0, 1, 0, 5'b00000);
      chk("sim.count15", int'(wr_count), 15);
      chk("sim.full_pre", int'(full), 0);
      for (int j = 1; j <= 2; j++) begin
         step(0, 0, 0, 5'b00001);
         chk($sformatf("sim.wait%0d.count", j), int'(wr_count), 15);
         chk($sformatf("sim.wait%0d.full", j), int'(full), 0);
      end
      step(0, 1, 0, 5'b00001);
      chk("sim.edge.b_wptr", int'(b_wptr), 16);
      chk("sim.edge.count", int'(wr_count), 15);
      chk("sim.edge.full", int'(full), 0);
      chk("sim.edge.afull", int'(almost_full), 1);
      step(0, 0, 0, 5'b00001);
      chk("sim.after.count", int'(wr_count), 15);
      chk("sim.after.full", int'(full), 0);
      step(0, 1, 0, 5'b00001);
      chk("sim.last.b_wptr", int'(b_wptr), 17);
      chk("sim.last.count", int'(wr_count), 16);
      chk("sim.last.full", int'(full), 1);
      step(0, 1, 0, 5'b00001);
      chk("sim.ovf", int'(overflow), 1);
      chk("sim.ovf.b_wptr", int'(b_wptr), 17);

      // reset mid-operation with a write pending clears everything
      step(1, 1, 0, 5'b00001);
      chk("rst.b_wptr", int'(b_wptr), 0);
      chk("rst.g_wptr", int'(g_wptr), 0);
      chk("rst.full", int'(full), 0);
      chk("rst.afull", int'(almost_full), 0);
      chk("rst.count", int'(wr_count), 0);
      chk("rst.overflow", int'(overflow), 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
